// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and geometry helpers for the fetch stage
//
// Contents:
//   fetch_state_e : refill FSM encoding (ST_LOOKUP, ST_MISS)
//   NOP_INSTR     : word presented to decode when no instruction is available
//   index_bits / offset_bits / tag_bits : address-split widths from NLINES / LINE_WORDS
package fetch_pkg;

  typedef enum logic {
    ST_LOOKUP = 1'b0,
    ST_MISS   = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int index_bits(input int nlines);
    return $clog2(nlines);
  endfunction

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  // Byte offset [1:0] is always dropped; the tag is whatever is left above the index.
  function automatic int tag_bits(input int nlines, input int line_words);
    return 32 - 2 - $clog2(nlines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/fetch_icache_if.sv
// rtl/fetch_icache_if.sv - line refill bus between the fetch cache and memory
//
// Signals:
//   mem_req   : refill request, held high until mem_valid
//   mem_addr  : line-aligned refill address, stable while mem_req=1
//   mem_valid : one-cycle pulse carrying the refill line
//   mem_rdata : refill line, word 0 in bits [31:0]
// Modports: master (cache side), slave (memory side).
interface fetch_icache_if #(
  parameter int LINE_WORDS = 4
) ();

  logic                      mem_req;
  logic [31:0]               mem_addr;
  logic                      mem_valid;
  logic [32*LINE_WORDS-1:0]  mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_rdata
  );

endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - direct-mapped line storage: data, tag and valid bits
//
// Ports:
//   clk, reset       : clock, asynchronous active-low reset (clears valid bits only)
//   flush            : clear every valid bit at the clock edge; wins over a same-cycle write
//   rd_index         : combinational read port index
//   rd_valid/rd_tag/rd_line : stored state of that line
//   wr_en/wr_index/wr_tag/wr_line : line fill port
module icache_array
  import fetch_pkg::*;
#(
  parameter int NLINES     = 4,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = tag_bits(NLINES, LINE_WORDS),
  localparam int IDX_W     = index_bits(NLINES),
  localparam int LINE_W    = 32 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [LINE_W-1:0] data_mem [NLINES];
  logic [TAG_W-1:0]  tag_mem  [NLINES];
  logic [NLINES-1:0] valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Data and tags need no reset: they are never looked at while the valid bit is 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index] <= wr_line;
      tag_mem[wr_index]  <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/fetch_icache.sv
// rtl/fetch_icache.sv - fetch stage: PC, direct-mapped instruction cache and refill FSM
//
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   dhit           : pipeline advance; 0 freezes the PC and ignores redirect
//   redirect, redirect_pc : taken branch/jump and its target (bits [1:0] ignored)
//   icache_flush   : invalidate all lines
//   instr, pc_f, ihit : fetched word (NOP when ihit=0), fetch PC, word valid
//   mem            : refill bus (fetch_icache_if.master)
//   perf_hits, perf_misses : present only when FETCH_PERF_EN is defined
// Optional feature macro: FETCH_PERF_EN (hit/miss performance counters).
module fetch_icache
  import fetch_pkg::*;
#(
  parameter int          NLINES     = 4,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dhit,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        icache_flush,
  output logic [31:0] instr,
  output logic [31:0] pc_f,
  output logic        ihit,
  fetch_icache_if.master mem
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);

  localparam int OFF_W   = offset_bits(LINE_WORDS);
  localparam int OFF_WS  = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W   = index_bits(NLINES);
  localparam int TAG_W   = tag_bits(NLINES, LINE_WORDS);
  localparam int LINE_W  = 32 * LINE_WORDS;
  localparam int IDX_LSB = 2 + OFF_W;
  localparam logic [31:0] LINE_MASK = (32'd1 << IDX_LSB) - 32'd1;

  fetch_state_e state_q, state_d;

  logic [31:0]       pc_q;
  logic [31:0]       mem_addr_q;
  logic              capture;
  logic              fill_en;

  logic [IDX_W-1:0]  pc_index;
  logic [TAG_W-1:0]  pc_tag;
  logic [OFF_WS-1:0] pc_word;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic [31:0]       line_word;

  assign pc_index = pc_q[IDX_LSB +: IDX_W];
  assign pc_tag   = pc_q[31 -: TAG_W];
  assign pc_word  = (OFF_W > 0) ? pc_q[2 +: OFF_WS] : '0;

  icache_array #(
    .NLINES     (NLINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .flush    (icache_flush),
    .rd_index (pc_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill_en),
    .wr_index (mem_addr_q[IDX_LSB +: IDX_W]),
    .wr_tag   (mem_addr_q[31 -: TAG_W]),
    .wr_line  (mem.mem_rdata)
  );

  always_comb begin
    line_word = rd_line[31:0];
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (pc_word == w[OFF_WS-1:0]) begin
        line_word = rd_line[w*32 +: 32];
      end
    end
  end

  // Hit is purely combinational from the registered PC; MISS never reports a hit.
  assign ihit  = (state_q == ST_LOOKUP) && rd_valid && (rd_tag == pc_tag);
  assign instr = ihit ? line_word : NOP_INSTR;
  assign pc_f  = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOOKUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    fill_en = 1'b0;
    case (state_q)
      ST_LOOKUP: begin
        // A miss in a flush cycle waits for the next lookup instead of refilling.
        if (!ihit && !icache_flush) begin
          state_d = ST_MISS;
          capture = 1'b1;
        end
      end
      ST_MISS: begin
        // A same-cycle flush still ends the refill; the array keeps the line invalid.
        if (mem.mem_valid) begin
          state_d = ST_LOOKUP;
          fill_en = 1'b1;
        end
      end
      default: state_d = ST_LOOKUP;
    endcase
  end

  // mem_req comes straight from the async-reset state so reset drops it immediately.
  assign mem.mem_req  = (state_q == ST_MISS);
  assign mem.mem_addr = mem_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q <= '0;
    end else if (capture) begin
      mem_addr_q <= pc_q & ~LINE_MASK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (dhit) begin
      if (redirect) begin
        pc_q <= redirect_pc & ~32'h3;
      end else if (ihit) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (ihit && dhit) begin
        perf_hits <= perf_hits + 32'd1;
      end
      if (capture) begin
        perf_misses <= perf_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_icache.sv
// tb/tb_fetch_icache.sv - self-checking bench for fetch_icache
module tb_fetch_icache;
  import fetch_pkg::*;

  localparam int          NLINES     = 4;
  localparam int          LINE_WORDS = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_1000;
  localparam int          LINE_BYTES = 4 * LINE_WORDS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dhit = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        icache_flush = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_f;
  logic        ihit;

  fetch_icache_if #(.LINE_WORDS(LINE_WORDS)) mem ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_hits;
  logic [31:0] perf_misses;
`endif

  fetch_icache #(
    .NLINES     (NLINES),
    .LINE_WORDS (LINE_WORDS),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dhit         (dhit),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .icache_flush (icache_flush),
    .instr        (instr),
    .pc_f         (pc_f),
    .ihit         (ihit),
    .mem          (mem)
`ifdef FETCH_PERF_EN
    ,
    .perf_hits    (perf_hits),
    .perf_misses  (perf_misses)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: the line at 0x1000 holds 1,2,3,4; every other word is address-derived.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h000_0100) return 32'(a[3:2]) + 32'd1;
    return (a & ~32'h3) ^ 32'hA000_0000;
  endfunction

  function automatic logic [32*LINE_WORDS-1:0] mem_line(input logic [31:0] base);
    logic [32*LINE_WORDS-1:0] l;
    for (int i = 0; i < LINE_WORDS; i++) l[i*32 +: 32] = mem_word(base + 32'(4*i));
    return l;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    dhit = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    icache_flush = 1'b0;
    mem.mem_valid = 1'b0;
    mem.mem_rdata = '0;
    @(negedge clk);
    check32("rst_pc", pc_f, RESET_PC);
    check32("rst_ihit", 32'(ihit), 32'd0);
    check32("rst_req", 32'(mem.mem_req), 32'd0);
    check32("rst_addr", mem.mem_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic wait_req(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem.mem_req) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_req: mem_req still 0 after %0d cycles, expected 1", budget);
    end
  endtask

  typedef struct {
    logic        d;
    logic        r;
    logic [31:0] rpc;
    logic        mv;
    logic        e_ihit;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mkv(input logic d, input logic r, input logic [31:0] rpc, input logic mv,
                               input logic e_ihit, input logic [31:0] e_instr, input logic [31:0] e_pc,
                               input logic e_req, input logic [31:0] e_addr);
    vec_t v;
    v.d = d; v.r = r; v.rpc = rpc; v.mv = mv;
    v.e_ihit = e_ihit; v.e_instr = e_instr; v.e_pc = e_pc; v.e_req = e_req; v.e_addr = e_addr;
    return v;
  endfunction

  vec_t vt [17];

  // Reference model state: which line base each index holds, plus the outstanding refill.
  bit          m_present [NLINES];
  logic [31:0] m_base    [NLINES];
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_addr;
  int          m_delay;
  logic [31:0] m_hits, m_misses;

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic int index_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % NLINES);
  endfunction

  function automatic logic [31:0] pick_target();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return (32'h1000 + (32'($urandom_range(0, 95)) << 2)) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    // ---------------- table: cold miss, fill, stepping, dhit freeze, redirect during MISS
    vt[0]  = mkv(1, 0, 0,            0, 0, NOP_INSTR, 32'h1000, 0, 32'h0);
    vt[1]  = mkv(1, 0, 0,            0, 0, NOP_INSTR, 32'h1000, 1, 32'h1000);
    vt[2]  = mkv(1, 0, 0,            0, 0, NOP_INSTR, 32'h1000, 1, 32'h1000);
    vt[3]  = mkv(1, 0, 0,            1, 0, NOP_INSTR, 32'h1000, 1, 32'h1000);
    vt[4]  = mkv(1, 0, 0,            0, 1, 32'h1,     32'h1000, 0, 32'h1000);
    vt[5]  = mkv(0, 1, 32'h2000,     0, 1, 32'h2,     32'h1004, 0, 32'h1000);
    vt[6]  = mkv(0, 1, 32'h2000,     0, 1, 32'h2,     32'h1004, 0, 32'h1000);
    vt[7]  = mkv(0, 1, 32'h2000,     0, 1, 32'h2,     32'h1004, 0, 32'h1000);
    vt[8]  = mkv(1, 1, 32'h1008,     0, 1, 32'h2,     32'h1004, 0, 32'h1000);
    vt[9]  = mkv(1, 0, 0,            0, 1, 32'h3,     32'h1008, 0, 32'h1000);
    vt[10] = mkv(1, 0, 0,            0, 1, 32'h4,     32'h100C, 0, 32'h1000);
    vt[11] = mkv(1, 0, 0,            0, 0, NOP_INSTR, 32'h1010, 0, 32'h1000);
    vt[12] = mkv(1, 1, 32'h2000,     0, 0, NOP_INSTR, 32'h1010, 1, 32'h1010);
    vt[13] = mkv(1, 0, 0,            0, 0, NOP_INSTR, 32'h2000, 1, 32'h1010);
    vt[14] = mkv(1, 0, 0,            1, 0, NOP_INSTR, 32'h2000, 1, 32'h1010);
    vt[15] = mkv(1, 0, 0,            0, 0, NOP_INSTR, 32'h2000, 0, 32'h1010);
    vt[16] = mkv(1, 0, 0,            0, 0, NOP_INSTR, 32'h2000, 1, 32'h2000);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      dhit          = vt[i].d;
      redirect      = vt[i].r;
      redirect_pc   = vt[i].rpc;
      mem.mem_valid = vt[i].mv;
      mem.mem_rdata = vt[i].mv ? mem_line(vt[i].e_addr) : '0;
      @(negedge clk);
      check32($sformatf("vec%0d_ihit", i), 32'(ihit), 32'(vt[i].e_ihit));
      check32($sformatf("vec%0d_instr", i), instr, vt[i].e_instr);
      check32($sformatf("vec%0d_pc", i), pc_f, vt[i].e_pc);
      check32($sformatf("vec%0d_req", i), 32'(mem.mem_req), 32'(vt[i].e_req));
      check32($sformatf("vec%0d_addr", i), mem.mem_addr, vt[i].e_addr);
      @(posedge clk); #1;
    end
    mem.mem_valid = 1'b0;
    redirect = 1'b0;
    dhit = 1'b1;

    // ---------------- flush coinciding with mem_valid: line stays invalid, same miss again
    do_reset();
    wait_req(10);
    mem.mem_valid = 1'b1;
    mem.mem_rdata = mem_line(32'h1000);
    icache_flush = 1'b1;
    @(posedge clk); #1;
    mem.mem_valid = 1'b0;
    icache_flush = 1'b0;
    @(negedge clk);
    check32("flush_fill_ihit", 32'(ihit), 32'd0);
    check32("flush_fill_req", 32'(mem.mem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check32("flush_remiss_req", 32'(mem.mem_req), 32'd1);
    check32("flush_remiss_addr", mem.mem_addr, 32'h1000);
    mem.mem_valid = 1'b1;
    mem.mem_rdata = mem_line(32'h1000);
    @(posedge clk); #1;
    mem.mem_valid = 1'b0;
    @(negedge clk);
    check32("refill_ihit", 32'(ihit), 32'd1);
    check32("refill_instr", instr, 32'h1);

    // ---------------- conflict: 0x1040 evicts 0x1000 from index 0
    redirect = 1'b1;
    redirect_pc = 32'h1040;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check32("conf_pc", pc_f, 32'h1040);
    check32("conf_ihit", 32'(ihit), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check32("conf_req", 32'(mem.mem_req), 32'd1);
    check32("conf_addr", mem.mem_addr, 32'h1040);
    mem.mem_valid = 1'b1;
    mem.mem_rdata = mem_line(32'h1040);
    @(posedge clk); #1;
    mem.mem_valid = 1'b0;
    @(negedge clk);
    check32("conf_hit", 32'(ihit), 32'd1);
    check32("conf_instr", instr, mem_word(32'h1040));
    redirect = 1'b1;
    redirect_pc = 32'h1000;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check32("conf_back_ihit", 32'(ihit), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check32("conf_back_addr", mem.mem_addr, 32'h1000);
    check32("conf_back_req", 32'(mem.mem_req), 32'd1);

    // ---------------- async reset mid-MISS, then a late mem_valid in LOOKUP
    mem.mem_valid = 1'b1;
    mem.mem_rdata = mem_line(32'h1000);
    @(posedge clk); #1;
    mem.mem_valid = 1'b0;
    @(negedge clk);
    check32("pre_rst_hit", 32'(ihit), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h1050;
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_req(10);
    #2;
    reset = 1'b0;
    #1;
    check32("async_rst_req", 32'(mem.mem_req), 32'd0);
    check32("async_rst_pc", pc_f, RESET_PC);
    @(posedge clk); #1;
    reset = 1'b1;
    mem.mem_valid = 1'b1;
    mem.mem_rdata = {LINE_WORDS{32'hFFFF_FFFF}};
    @(negedge clk);
    check32("post_rst_ihit", 32'(ihit), 32'd0);
    check32("post_rst_pc", pc_f, 32'h1000);
    @(posedge clk); #1;
    mem.mem_valid = 1'b0;
    @(negedge clk);
    check32("post_rst_req", 32'(mem.mem_req), 32'd1);
    check32("post_rst_addr", mem.mem_addr, 32'h1000);
    @(posedge clk); #1;
    @(negedge clk);
    check32("late_valid_ignored", 32'(mem.mem_req), 32'd1);
    mem.mem_valid = 1'b1;
    mem.mem_rdata = mem_line(32'h1000);
    @(posedge clk); #1;
    mem.mem_valid = 1'b0;
    @(negedge clk);
    check32("post_rst_instr", instr, 32'h1);

    // ---------------- randomized run against the reference model
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < NLINES; i++) begin
      m_present[i] = 1'b0;
      m_base[i] = '0;
    end
    m_pc = RESET_PC;
    m_pend = 1'b0;
    m_addr = '0;
    m_delay = 0;
    m_hits = '0;
    m_misses = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit          exp_hit;
      logic [31:0] old_pc;
      dhit         = ($urandom_range(0, 4) != 0);
      redirect     = ($urandom_range(0, 7) == 0);
      redirect_pc  = pick_target();
      icache_flush = ($urandom_range(0, 39) == 0);
      if (m_pend) begin
        if (m_delay == 0) begin
          mem.mem_valid = 1'b1;
          mem.mem_rdata = mem_line(m_addr);
        end else begin
          mem.mem_valid = 1'b0;
          m_delay--;
        end
      end else begin
        mem.mem_valid = ($urandom_range(0, 15) == 0);
        mem.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      exp_hit = !m_pend && m_present[index_of(m_pc)] && (m_base[index_of(m_pc)] == line_of(m_pc));
      check32("rnd_ihit", 32'(ihit), 32'(exp_hit));
      check32("rnd_instr", instr, exp_hit ? mem_word(m_pc) : NOP_INSTR);
      check32("rnd_pc", pc_f, m_pc);
      check32("rnd_req", 32'(mem.mem_req), 32'(m_pend));
      check32("rnd_addr", mem.mem_addr, m_addr);
      old_pc = m_pc;
      if (exp_hit && dhit) m_hits++;
      if (dhit) begin
        if (redirect) m_pc = redirect_pc & ~32'h3;
        else if (exp_hit) m_pc = m_pc + 32'd4;
      end
      if (m_pend) begin
        if (mem.mem_valid) begin
          if (!icache_flush) begin
            m_present[index_of(m_addr)] = 1'b1;
            m_base[index_of(m_addr)] = m_addr;
          end
          m_pend = 1'b0;
        end
      end else if (!exp_hit && !icache_flush) begin
        m_pend = 1'b1;
        m_addr = line_of(old_pc);
        m_delay = $urandom_range(0, 4);
        m_misses++;
      end
      if (icache_flush) begin
        for (int i = 0; i < NLINES; i++) m_present[i] = 1'b0;
      end
      @(posedge clk); #1;
    end
`ifdef FETCH_PERF_EN
    @(negedge clk);
    check32("perf_hits", perf_hits, m_hits);
    check32("perf_misses", perf_misses, m_misses);
`endif
    mem.mem_valid = 1'b0;
    icache_flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
